sr_deserializer: RTL and testbench
==================================

Name: sr_deserializer

Overview:
- Receive end of the serial stream emitted on the shift register's shiftout pin.
- The shift register shifts left, so words arrive MSB first, one bit per enabled clock.
- This block frames the bits and rebuilds WIDTH-bit parallel words.
- Completed words are presented through a valid/ready holding register to downstream logic, with sticky overrun and framing-error flags.

Parameters:
- WIDTH, 8, bits per word; legal range 2..32.
- CW, $clog2(WIDTH), width of the internal bit counter.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- sclr  input  1  synchronous active-high reset; highest priority of all inputs.
- enable  input  1  bit strobe; serial_in and frame are sampled only when enable=1.
- serial_in  input  1  serial data, MSB first; connects to the shift register's shiftout.
- frame  input  1  start-of-word marker; asserted with enable on the MSB bit.
- q  output  WIDTH  assembled word, held stable while q_valid=1.
- q_valid  output  1  q holds an unconsumed word.
- q_ready  input  1  consumer accepts q this cycle when q_valid=1.
- busy  output  1  a word is partially assembled (FSM in SHIFT).
- overrun  output  1  sticky; a completed word was dropped because the holding register was full.
- frame_err  output  1  sticky; frame arrived while a word was partially assembled.

Behaviour:
- Reset (sclr=1 at an edge):
  - q=0, q_valid=0, busy=0, overrun=0, frame_err=0.
  - Shift register and counter cleared; FSM to IDLE.
  - Reset overrides every other input in the same cycle, including mid-word and while q_valid=1.
- FSM states: IDLE, SHIFT. busy=1 exactly when the state is SHIFT.
- IDLE:
  - enable=1 and frame=1: shreg <= {shreg[WIDTH-2:0], serial_in}, cnt <= 1, go to SHIFT.
  - enable=1 and frame=0: bit ignored; stay in IDLE (hunting for a word start).
- SHIFT, enable=1:
  - serial_in shifts into the LSB and cnt increments.
  - When cnt == WIDTH-1, this bit completes the word: word = {shreg[WIDTH-2:0], serial_in}, go to IDLE, cnt <= 0.
- SHIFT, enable=1 and frame=1:
  - Resynchronise: discard the partial word and set frame_err=1.
  - The current bit becomes the new MSB, cnt <= 1, stay in SHIFT.
  - frame takes precedence over word completion on the same bit.
- enable=0 in any state: shreg, cnt and FSM hold; frame and serial_in are ignored.
- Bit ordering: the first (framed) bit lands in q[WIDTH-1]; the last bit lands in q[0].
- Latency: q and q_valid update at the same edge that samples the last bit, i.e. they are visible the cycle after that bit is presented.
- Holding register, on a completion cycle:
  - If q_valid=0, or q_valid=1 and q_ready=1: load q <= word, q_valid <= 1.
  - If q_valid=1 and q_ready=0: the word is dropped, q is unchanged and overrun <= 1.
- Holding register, on a non-completion cycle: q_valid=1 and q_ready=1 clears q_valid; q keeps its last value.
- q_ready while q_valid=0 has no effect.
- overrun and frame_err clear only on sclr.
- Back-to-back words are supported with zero idle bits: a framed MSB may follow the LSB on the very next enabled clock.

Decomposition:
- Shared package sr_pkg:
  - State constants S_IDLE=0, S_SHIFT=1.
  - Default word width constant SR_WIDTH=8, shared with the sr shift register.
- One sub-module, sr_deser_outbuf: the valid/ready holding register.
  - Inputs: clock, sclr, word, word_done, q_ready.
  - Outputs: q, q_valid, overrun.
- Top level keeps the FSM, shift register and bit counter.

Test Plan (WIDTH=8):
- Reset mid-word: sclr during bit 4 of a word, then idle → all outputs 0 the next cycle; the next framed word 8'hA5 arrives intact with q_valid=1.
- Basic word: frame with the first bit, then bits 1,0,1,0,0,1,0,1 on consecutive enabled clocks, q_ready=1 → q=8'hA5, q_valid=1 for one cycle after the 8th edge, busy=1 during bits 1..7.
- Enable gaps: same word with enable=0 inserted between every bit → q=8'hA5; completion occurs only after the 8th enabled bit.
- Back-to-back with stalls: words 8'h3C then 8'hC3 with no gap and q_ready=0 → q=8'h3C held, q_valid=1, overrun=1, 8'hC3 dropped. Then q_ready=1 for one cycle → q_valid=0.
- Resync: framed word aborted after 5 bits, new frame then 8'h81 → frame_err=1, q=8'h81, no spurious word from the partial bits.
- Loopback: drive the sr shift register (load 8'h5E, then shift with enable) into this block with frame pulsed on the first shift → q=8'h5E.

Source files
------------

// File: rtl/sr_pkg.sv
// Shared definitions for the serial shift-register family: FSM state
// encoding and the default word width used by both ends of the link.
package sr_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } sr_state_e;

  localparam int SR_WIDTH = 8;

endpackage : sr_pkg

// File: rtl/sr_deser_outbuf.sv
// Valid/ready holding register for completed words, with a sticky
// overrun flag raised when a word arrives while the register is still full.
module sr_deser_outbuf
  import sr_pkg::*;
#(
  parameter int WIDTH = SR_WIDTH
) (
  input  logic             clock,
  input  logic             sclr,
  input  logic [WIDTH-1:0] word,
  input  logic             word_done,
  input  logic             q_ready,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic             overrun
);

  logic [WIDTH-1:0] q_r;
  logic             q_valid_r;
  logic             overrun_r;

  // Holding register: a consume in the same cycle frees the slot for a new word
  always_ff @(posedge clock) begin
    if (sclr) begin
      q_r       <= {WIDTH{1'b0}};
      q_valid_r <= 1'b0;
      overrun_r <= 1'b0;
    end else if (word_done) begin
      if (!q_valid_r || q_ready) begin
        q_r       <= word;
        q_valid_r <= 1'b1;
      end else begin
        overrun_r <= 1'b1;
      end
    end else if (q_valid_r && q_ready) begin
      q_valid_r <= 1'b0;
    end else begin
      q_valid_r <= q_valid_r;
    end
  end

  assign q       = q_r;
  assign q_valid = q_valid_r;
  assign overrun = overrun_r;

endmodule : sr_deser_outbuf

// File: rtl/sr_deserializer.sv
// Receive end of the MSB-first serial link: frames incoming bits, rebuilds
// WIDTH-bit words and hands them to a valid/ready holding register.
module sr_deserializer
  import sr_pkg::*;
#(
  parameter int WIDTH = SR_WIDTH,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             sclr,
  input  logic             enable,
  input  logic             serial_in,
  input  logic             frame,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  input  logic             q_ready,
  output logic             busy,
  output logic             overrun,
  output logic             frame_err
);

  sr_state_e        state_r, state_s;
  logic [WIDTH-2:0] shreg_r, shreg_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic             frame_err_r, frame_err_s;
  logic             busy_r;
  logic [WIDTH-1:0] shift_s;
  logic             word_done_s;

  // Framing FSM; only WIDTH-1 partial bits are stored, the last bit completes the word directly
  always_comb begin
    shift_s     = {shreg_r, serial_in};
    state_s     = state_r;
    shreg_s     = shreg_r;
    cnt_s       = cnt_r;
    frame_err_s = frame_err_r;
    word_done_s = 1'b0;
    if (enable) begin
      case (state_r)
        S_IDLE: begin
          if (frame) begin
            shreg_s = shift_s[WIDTH-2:0];
            cnt_s   = CW'(1);
            state_s = S_SHIFT;
          end else begin
            state_s = S_IDLE;
          end
        end
        S_SHIFT: begin
          // A new frame marker wins over completing the current word
          if (frame) begin
            frame_err_s = 1'b1;
            shreg_s     = shift_s[WIDTH-2:0];
            cnt_s       = CW'(1);
          end else if (cnt_r == CW'(WIDTH - 1)) begin
            word_done_s = 1'b1;
            shreg_s     = shift_s[WIDTH-2:0];
            cnt_s       = {CW{1'b0}};
            state_s     = S_IDLE;
          end else begin
            shreg_s = shift_s[WIDTH-2:0];
            cnt_s   = cnt_r + CW'(1);
          end
        end
        default: begin
          state_s = S_IDLE;
          cnt_s   = {CW{1'b0}};
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Framing state registers
  always_ff @(posedge clock) begin
    if (sclr) begin
      state_r     <= S_IDLE;
      shreg_r     <= {(WIDTH-1){1'b0}};
      cnt_r       <= {CW{1'b0}};
      frame_err_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      shreg_r     <= shreg_s;
      cnt_r       <= cnt_s;
      frame_err_r <= frame_err_s;
      busy_r      <= (state_s == S_SHIFT);
    end
  end

  sr_deser_outbuf #(.WIDTH(WIDTH)) u_outbuf (
    .clock     (clock),
    .sclr      (sclr),
    .word      (shift_s),
    .word_done (word_done_s),
    .q_ready   (q_ready),
    .q         (q),
    .q_valid   (q_valid),
    .overrun   (overrun)
  );

  assign busy      = busy_r;
  assign frame_err = frame_err_r;

endmodule : sr_deserializer

// File: tb/tb_sr_deserializer.sv
// Self-checking bench for sr_deserializer: directed scenarios with literal
// expectations plus a randomized run checked cycle by cycle against a word-level model.
module tb_sr_deserializer;

  localparam int W = 8;

  logic         clock;
  logic         sclr;
  logic         enable;
  logic         serial_in;
  logic         frame;
  logic [W-1:0] q;
  logic         q_valid;
  logic         q_ready;
  logic         busy;
  logic         overrun;
  logic         frame_err;

  int n_cmp;
  int n_fail;

  // reference model: word being collected as an integer plus the holding slot
  bit          m_inword;
  int          m_nbits;
  int unsigned m_val;
  int unsigned m_q;
  bit          m_qv;
  bit          m_ovr;
  bit          m_ferr;

  sr_deserializer #(.WIDTH(W)) dut (
    .clock     (clock),
    .sclr      (sclr),
    .enable    (enable),
    .serial_in (serial_in),
    .frame     (frame),
    .q         (q),
    .q_valid   (q_valid),
    .q_ready   (q_ready),
    .busy      (busy),
    .overrun   (overrun),
    .frame_err (frame_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_update(input bit en, input bit sin, input bit frm, input bit rdy, input bit clr);
    bit done;
    done = 1'b0;
    if (clr) begin
      m_inword = 1'b0; m_nbits = 0; m_val = 0;
      m_q = 0; m_qv = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
    end else begin
      if (en) begin
        if (frm) begin
          if (m_inword) m_ferr = 1'b1;
          m_inword = 1'b1;
          m_nbits  = 1;
          m_val    = sin;
        end else if (m_inword) begin
          m_val   = m_val * 2 + sin;
          m_nbits = m_nbits + 1;
          if (m_nbits == W) begin
            done     = 1'b1;
            m_inword = 1'b0;
            m_nbits  = 0;
          end
        end
      end
      if (done) begin
        if (!m_qv || rdy) begin
          m_q  = m_val % (1 << W);
          m_qv = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_qv && rdy) begin
        m_qv = 1'b0;
      end
    end
  endtask

  // one clock: drive, advance model, wait for the edge, compare on the falling edge
  task automatic step(input bit en, input bit sin, input bit frm, input bit rdy, input bit clr);
    enable    = en;
    serial_in = sin;
    frame     = frm;
    q_ready   = rdy;
    sclr      = clr;
    model_update(en, sin, frm, rdy, clr);
    @(posedge clock);
    @(negedge clock);
    check("q",         32'(q),         m_q);
    check("q_valid",   32'(q_valid),   32'(m_qv));
    check("busy",      32'(busy),      32'(m_inword));
    check("overrun",   32'(overrun),   32'(m_ovr));
    check("frame_err", 32'(frame_err), 32'(m_ferr));
  endtask

  task automatic send_bits(input logic [W-1:0] val, input int nbits, input bit gaps, input bit rdy);
    for (int i = W - 1; i >= W - nbits; i--) begin
      step(1'b1, val[i], (i == W - 1), rdy, 1'b0);
      if (gaps) step(1'b0, 1'b0, 1'b1, rdy, 1'b0);
    end
  endtask

  initial begin
    logic [W-1:0] lb;
    n_cmp = 0; n_fail = 0;
    enable = 1'b0; serial_in = 1'b0; frame = 1'b0; q_ready = 1'b0; sclr = 1'b1;
    @(negedge clock);

    // reset state
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    check("rst_q", 32'(q), 32'h0);
    check("rst_flags", {27'h0, q_valid, busy, overrun, frame_err, 1'b0}, 32'h0);

    // reset mid-word, then a clean word
    send_bits(8'hA5, 4, 1'b0, 1'b0);
    check("midword_busy", 32'(busy), 32'h1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("midword_rst", {q, q_valid, busy, overrun, frame_err}, 32'h0);
    send_bits(8'hA5, 8, 1'b0, 1'b0);
    check("after_rst_q", 32'(q), 32'hA5);
    check("after_rst_qv", 32'(q_valid), 32'h1);

    // basic word with consumer always ready
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_bits(8'hA5, 8, 1'b0, 1'b1);
    check("basic_q", 32'(q), 32'hA5);
    check("basic_qv", 32'(q_valid), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("basic_consumed", 32'(q_valid), 32'h0);

    // enable gaps with frame toggling while disabled
    send_bits(8'h5A, 7, 1'b1, 1'b1);
    check("gap_not_done", 32'(q_valid), 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("gap_q", 32'(q), 32'h5A);
    check("gap_qv", 32'(q_valid), 32'h1);

    // back-to-back with stalled consumer
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send_bits(8'h3C, 8, 1'b0, 1'b0);
    send_bits(8'hC3, 8, 1'b0, 1'b0);
    check("b2b_q", 32'(q), 32'h3C);
    check("b2b_ovr", {30'h0, q_valid, overrun}, 32'h3);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("b2b_drain", {30'h0, q_valid, overrun}, 32'h1);

    // resync: abort after 5 bits
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send_bits(8'hFF, 5, 1'b0, 1'b1);
    send_bits(8'h81, 8, 1'b0, 1'b1);
    check("resync_q", 32'(q), 32'h81);
    check("resync_ferr", {30'h0, q_valid, frame_err}, 32'h3);

    // loopback from a left-shifting register loaded with 5E
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    lb = 8'h5E;
    for (int i = 0; i < W; i++) begin
      step(1'b1, lb[W-1], (i == 0), 1'b1, 1'b0);
      lb = {lb[W-2:0], 1'b0};
    end
    check("loop_q", 32'(q), 32'h5E);
    check("loop_qv", 32'(q_valid), 32'h1);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      step(($urandom_range(3) != 0), 1'($urandom), ($urandom_range(9) == 0),
           1'($urandom), ($urandom_range(299) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_sr_deserializer
